// File: rtl/mem_adapter_pkg.sv
// ---------------------------------------------------------------------------
// mem_adapter_pkg
// Shared types for the core-to-RAM adapter: the core request encoding,
// the adapter state encoding, byte-lane mask constants and small decode
// helpers used by both the adapter and its lane-alignment sub-module.
// ---------------------------------------------------------------------------
package mem_adapter_pkg;

   typedef enum logic [2:0] {
      MEM_NONE       = 3'd0,
      MEM_READ_BYTE  = 3'd1,
      MEM_READ_HALF  = 3'd2,
      MEM_READ_WORD  = 3'd3,
      MEM_STORE_BYTE = 3'd4,
      MEM_STORE_HALF = 3'd5,
      MEM_STORE_WORD = 3'd6
   } mem_ctrl_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SECOND = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Right-aligned byte-lane masks for each access size
   localparam logic [3:0] LANE_MASK_NONE = 4'b0000;
   localparam logic [3:0] LANE_MASK_BYTE = 4'b0001;
   localparam logic [3:0] LANE_MASK_HALF = 4'b0011;
   localparam logic [3:0] LANE_MASK_WORD = 4'b1111;

   function automatic logic [3:0] lane_mask(input mem_ctrl_t c);
      logic [3:0] m;
      case (c)
         MEM_READ_BYTE, MEM_STORE_BYTE: m = LANE_MASK_BYTE;
         MEM_READ_HALF, MEM_STORE_HALF: m = LANE_MASK_HALF;
         MEM_READ_WORD, MEM_STORE_WORD: m = LANE_MASK_WORD;
         default:                       m = LANE_MASK_NONE;
      endcase
      return m;
   endfunction

   function automatic logic is_store(input mem_ctrl_t c);
      logic s;
      case (c)
         MEM_STORE_BYTE, MEM_STORE_HALF, MEM_STORE_WORD: s = 1'b1;
         default:                                        s = 1'b0;
      endcase
      return s;
   endfunction

   function automatic logic is_load(input mem_ctrl_t c);
      logic l;
      case (c)
         MEM_READ_BYTE, MEM_READ_HALF, MEM_READ_WORD: l = 1'b1;
         default:                                     l = 1'b0;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering for mem_adapter. The access is viewed as
// an 8-byte window {upper word, lower word}; the request is shifted left by
// the byte offset to place it in the window, and read data is shifted right
// by the same amount to right-align it.
// Configuration macro: MEM_ADAPTER_MISALIGN_EN (adds upper-word outputs and
// the captured-lower-word input; otherwise reports misalignment instead).
// Ports:
//   ctrl_i        core request type
//   offset_i      byte offset within the word (address bits [1:0])
//   store_data_i  right-aligned store data
//   rdata_i       RAM read data of the current access
//   capt_i        lower-word read data captured earlier (split loads)
//   spans_o       access crosses into the next word
//   be_hi_o/wdata_hi_o   byte enables / data for the upper word
//   misaligned_o  half/word not naturally aligned (split disabled)
//   be_lo_o/wdata_lo_o   byte enables / data for the lower word
//   load_data_o   right-aligned, zero-extended load data
// ---------------------------------------------------------------------------
module mem_lane_align
   import mem_adapter_pkg::*;
(
   input  mem_ctrl_t   ctrl_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
`ifdef MEM_ADAPTER_MISALIGN_EN
   input  logic [31:0] capt_i,
   output logic        spans_o,
   output logic [3:0]  be_hi_o,
   output logic [31:0] wdata_hi_o,
`else
   output logic        misaligned_o,
`endif
   output logic [3:0]  be_lo_o,
   output logic [31:0] wdata_lo_o,
   output logic [31:0] load_data_o
);

   logic [3:0]  size_mask_s;
   logic [4:0]  shamt_s;
   logic [7:0]  mask8_s;
   logic [63:0] wdata64_s;
   logic [63:0] rdata64_s;
   logic [63:0] win64_s;
   logic [31:0] keep_s;
   logic        unused_s;

   // Lane placement of enables/write data and right-alignment of read data
   always_comb begin
      size_mask_s = lane_mask(ctrl_i);
      shamt_s     = {offset_i, 3'b000};
      mask8_s     = {4'b0000, size_mask_s} << offset_i;
      wdata64_s   = {32'h0000_0000, store_data_i} << shamt_s;
      keep_s      = {{8{size_mask_s[3]}}, {8{size_mask_s[2]}},
                     {8{size_mask_s[1]}}, {8{size_mask_s[0]}}};
`ifdef MEM_ADAPTER_MISALIGN_EN
      spans_o    = |mask8_s[7:4];
      be_hi_o    = mask8_s[7:4];
      wdata_hi_o = wdata64_s[63:32];
      // A split load sees the lower word only through the capture register
      if (spans_o) begin
         rdata64_s = {rdata_i, capt_i};
      end else begin
         rdata64_s = {32'h0000_0000, rdata_i};
      end
`else
      rdata64_s = {32'h0000_0000, rdata_i};
      case (ctrl_i)
         MEM_READ_HALF, MEM_STORE_HALF: misaligned_o = offset_i[0];
         MEM_READ_WORD, MEM_STORE_WORD: misaligned_o = |offset_i;
         default:                       misaligned_o = 1'b0;
      endcase
`endif
      be_lo_o     = mask8_s[3:0];
      wdata_lo_o  = wdata64_s[31:0];
      win64_s     = rdata64_s >> shamt_s;
      load_data_o = win64_s[31:0] & keep_s;
   end

`ifdef MEM_ADAPTER_MISALIGN_EN
   assign unused_s = ^win64_s[63:32];
`else
   assign unused_s = ^{win64_s[63:32], mask8_s[7:4], wdata64_s[63:32]};
`endif

endmodule

// File: rtl/mem_adapter.sv
// ---------------------------------------------------------------------------
// mem_adapter
// Bridges a byte-addressed core load/store port to a 32-bit word RAM with
// per-byte write enables and one-cycle read latency. Little-endian.
// Configuration macro: MEM_ADAPTER_MISALIGN_EN
//   defined   : accesses crossing a word boundary are split into two RAM
//               cycles (lower word, then word+1 with wrap); mem_fault is 0.
//   undefined : misaligned half/word requests complete with mem_fault=1 and
//               never touch the RAM.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   mem_ctrl/mem_addr/mem_din core request, held until mem_ready
//   mem_dout/mem_ready/mem_fault  response (dout zero unless ready)
//   ram_addr/ram_en/ram_we/ram_wdata  RAM word access
//   ram_rdata                 RAM read data, one cycle after ram_en
// ---------------------------------------------------------------------------
module mem_adapter
   import mem_adapter_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  mem_ctrl_t         mem_ctrl,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_din,
   output logic [31:0]       mem_dout,
   output logic              mem_ready,
   output logic              mem_fault,
   output logic [ADDR_W-3:0] ram_addr,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   state_t            state_q, state_d;
   logic [ADDR_W-3:0] word_s;
   logic [3:0]        be_lo_s;
   logic [31:0]       wdata_lo_s;
   logic [31:0]       load_data_s;
   logic              store_s;
   logic              load_s;
   logic              unused_s;
   logic              ready_s, fault_s, en_s;
   logic [3:0]        we_s;
   logic [31:0]       dout_s, wdata_s;
   logic [ADDR_W-3:0] addr_s;
`ifdef MEM_ADAPTER_MISALIGN_EN
   logic [31:0]       capt_q, capt_d;
   logic              spans_s;
   logic [3:0]        be_hi_s;
   logic [31:0]       wdata_hi_s;
`else
   logic              fault_q, fault_d;
   logic              misaligned_s;
`endif

   // Bits above the RAM size are deliberately ignored
   assign word_s   = mem_addr[ADDR_W-1:2];
   assign unused_s = ^mem_addr[31:ADDR_W];
   assign store_s  = is_store(mem_ctrl);
   assign load_s   = is_load(mem_ctrl);

   mem_lane_align u_lane (
      .ctrl_i       (mem_ctrl),
      .offset_i     (mem_addr[1:0]),
      .store_data_i (mem_din),
      .rdata_i      (ram_rdata),
`ifdef MEM_ADAPTER_MISALIGN_EN
      .capt_i       (capt_q),
      .spans_o      (spans_s),
      .be_hi_o      (be_hi_s),
      .wdata_hi_o   (wdata_hi_s),
`else
      .misaligned_o (misaligned_s),
`endif
      .be_lo_o      (be_lo_s),
      .wdata_lo_o   (wdata_lo_s),
      .load_data_o  (load_data_s)
   );

   // Next-state, RAM command and response decode; reset forces outputs low
   always_comb begin
      state_d = state_q;
`ifdef MEM_ADAPTER_MISALIGN_EN
      capt_d  = capt_q;
`else
      fault_d = fault_q;
`endif
      en_s    = 1'b0;
      we_s    = 4'b0000;
      addr_s  = word_s;
      wdata_s = wdata_lo_s;
      ready_s = 1'b0;
      fault_s = 1'b0;
      dout_s  = 32'h0000_0000;
      case (state_q)
         ST_IDLE: begin
            if (mem_ctrl != MEM_NONE) begin
`ifdef MEM_ADAPTER_MISALIGN_EN
               en_s = 1'b1;
               we_s = store_s ? be_lo_s : 4'b0000;
               if (spans_s) begin
                  state_d = ST_SECOND;
               end else begin
                  state_d = ST_RESP;
               end
`else
               state_d = ST_RESP;
               if (misaligned_s) begin
                  fault_d = 1'b1;
               end else begin
                  fault_d = 1'b0;
                  en_s    = 1'b1;
                  we_s    = store_s ? be_lo_s : 4'b0000;
               end
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
`ifdef MEM_ADAPTER_MISALIGN_EN
         ST_SECOND: begin
            // Lower word arrives now; fetch/write word+1, wrapping at the top
            capt_d  = ram_rdata;
            en_s    = 1'b1;
            addr_s  = word_s + (ADDR_W-2)'(1);
            we_s    = store_s ? be_hi_s : 4'b0000;
            wdata_s = wdata_hi_s;
            state_d = ST_RESP;
         end
`endif
         ST_RESP: begin
            ready_s = 1'b1;
`ifdef MEM_ADAPTER_MISALIGN_EN
            fault_s = 1'b0;
            dout_s  = load_s ? load_data_s : 32'h0000_0000;
`else
            fault_s = fault_q;
            dout_s  = (load_s && !fault_q) ? load_data_s : 32'h0000_0000;
`endif
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (!rst) begin
         mem_ready = 1'b0;
         mem_fault = 1'b0;
         mem_dout  = 32'h0000_0000;
         ram_en    = 1'b0;
         ram_we    = 4'b0000;
      end else begin
         mem_ready = ready_s;
         mem_fault = fault_s;
         mem_dout  = dout_s;
         ram_en    = en_s;
         ram_we    = we_s;
      end
      ram_addr  = addr_s;
      ram_wdata = wdata_s;
   end

   // State and capture registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
`ifdef MEM_ADAPTER_MISALIGN_EN
         capt_q  <= 32'h0000_0000;
`else
         fault_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
`ifdef MEM_ADAPTER_MISALIGN_EN
         capt_q  <= capt_d;
`else
         fault_q <= fault_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_adapter.sv
// ---------------------------------------------------------------------------
// tb_mem_adapter
// Directed, table-driven bench for mem_adapter with a behavioural word RAM.
// Expected values adapt to whether MEM_ADAPTER_MISALIGN_EN is defined.
// ---------------------------------------------------------------------------
module tb_mem_adapter;
   import mem_adapter_pkg::*;

   localparam int ADDR_W = 12;
`ifdef MEM_ADAPTER_MISALIGN_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   mem_ctrl_t         mem_ctrl;
   logic [31:0]       mem_addr, mem_din, mem_dout;
   logic              mem_ready, mem_fault;
   logic [ADDR_W-3:0] ram_addr;
   logic              ram_en;
   logic [3:0]        ram_we;
   logic [31:0]       ram_wdata, ram_rdata;
   logic [31:0]       ram [0:1023];

   int total = 0;
   int bad   = 0;

   typedef struct {
      mem_ctrl_t   ctrl;
      logic [31:0] addr;
      logic [31:0] din;
      logic        chk_dout;
      logic [31:0] dout;
      logic        fault;
      int          lat;
      int          ens;
      logic [3:0]  we0;
      logic [3:0]  we1;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   mem_adapter #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_ctrl  (mem_ctrl),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .mem_ready (mem_ready),
      .mem_fault (mem_fault),
      .ram_addr  (ram_addr),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // Word RAM: byte-lane writes, registered read of the old contents
   always @(posedge clk) begin
      if (ram_en) begin
         for (int i = 0; i < 4; i++) begin
            if (ram_we[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
         end
         ram_rdata <= ram[ram_addr];
      end
   end

   function automatic vec_t mk(input mem_ctrl_t c, input logic [31:0] a, input logic [31:0] d,
                               input logic cd, input logic [31:0] o, input logic f,
                               input int l, input int e, input logic [3:0] w0, input logic [3:0] w1);
      vec_t v;
      v.ctrl = c; v.addr = a; v.din = d; v.chk_dout = cd; v.dout = o; v.fault = f;
      v.lat = l; v.ens = e; v.we0 = w0; v.we1 = w1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Issue one request and observe it until mem_ready (bounded)
   task automatic run_req(input mem_ctrl_t c, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] o_dout, output logic o_fault, output int o_lat,
                          output int o_ens, output logic [3:0] o_we0, output logic [3:0] o_we1,
                          output logic o_idle_ok);
      logic done;
      o_dout = 32'h0; o_fault = 1'b0; o_lat = -1; o_ens = 0;
      o_we0 = 4'h0; o_we1 = 4'h0; o_idle_ok = 1'b1; done = 1'b0;
      @(negedge clk);
      mem_ctrl = c; mem_addr = a; mem_din = d;
      #1;
      for (int cyc = 0; cyc < 8 && !done; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (ram_en) begin
            if (o_ens == 0) o_we0 = ram_we;
            else            o_we1 = ram_we;
            o_ens++;
         end
         if (mem_ready) begin
            o_dout = mem_dout; o_fault = mem_fault; o_lat = cyc; done = 1'b1;
         end else if (mem_dout != 32'h0) begin
            o_idle_ok = 1'b0;
         end
      end
      mem_ctrl = MEM_NONE;
   endtask

   initial begin
      vec_t        v;
      logic [31:0] r_dout;
      logic        r_fault, r_idle;
      int          r_lat, r_ens;
      logic [3:0]  r_we0, r_we1;

      // Preload through the adapter
      vecs.push_back(mk(MEM_STORE_WORD, 32'h010, 32'h11223344, 1'b0, 32'h0, 1'b0, 1, 1, 4'hF, 4'h0));
      vecs.push_back(mk(MEM_STORE_WORD, 32'h000, 32'hAA000000, 1'b0, 32'h0, 1'b0, 1, 1, 4'hF, 4'h0));
      vecs.push_back(mk(MEM_STORE_WORD, 32'h004, 32'h00CCBBDD, 1'b0, 32'h0, 1'b0, 1, 1, 4'hF, 4'h0));
      vecs.push_back(mk(MEM_STORE_WORD, 32'hFFC, 32'h55667788, 1'b0, 32'h0, 1'b0, 1, 1, 4'hF, 4'h0));
      vecs.push_back(mk(MEM_STORE_WORD, 32'h100, 32'h00000000, 1'b0, 32'h0, 1'b0, 1, 1, 4'hF, 4'h0));
      vecs.push_back(mk(MEM_STORE_WORD, 32'h200, 32'h00000000, 1'b0, 32'h0, 1'b0, 1, 1, 4'hF, 4'h0));
      // Aligned traffic
      vecs.push_back(mk(MEM_READ_WORD,  32'h010, 32'h0, 1'b1, 32'h11223344, 1'b0, 1, 1, 4'h0, 4'h0));
      vecs.push_back(mk(MEM_STORE_HALF, 32'h102, 32'h0000BEEF, 1'b0, 32'h0, 1'b0, 1, 1, 4'hC, 4'h0));
      vecs.push_back(mk(MEM_READ_BYTE,  32'h103, 32'h0, 1'b1, 32'h000000BE, 1'b0, 1, 1, 4'h0, 4'h0));
      vecs.push_back(mk(MEM_READ_BYTE,  32'h102, 32'h0, 1'b1, 32'h000000EF, 1'b0, 1, 1, 4'h0, 4'h0));
      vecs.push_back(mk(MEM_READ_HALF,  32'h102, 32'h0, 1'b1, 32'h0000BEEF, 1'b0, 1, 1, 4'h0, 4'h0));
      vecs.push_back(mk(MEM_READ_HALF,  32'h012, 32'h0, 1'b1, 32'h00001122, 1'b0, 1, 1, 4'h0, 4'h0));
      vecs.push_back(mk(MEM_READ_BYTE,  32'h011, 32'h0, 1'b1, 32'h00000033, 1'b0, 1, 1, 4'h0, 4'h0));
      vecs.push_back(mk(MEM_STORE_BYTE, 32'h201, 32'h0000005A, 1'b0, 32'h0, 1'b0, 1, 1, 4'h2, 4'h0));
      vecs.push_back(mk(MEM_READ_WORD,  32'h200, 32'h0, 1'b1, 32'h00005A00, 1'b0, 1, 1, 4'h0, 4'h0));
      vecs.push_back(mk(MEM_READ_WORD,  32'hFFFFF010, 32'h0, 1'b1, 32'h11223344, 1'b0, 1, 1, 4'h0, 4'h0));
      vecs.push_back(mk(MEM_STORE_BYTE, 32'h013, 32'hFFFFFF77, 1'b0, 32'h0, 1'b0, 1, 1, 4'h8, 4'h0));
      vecs.push_back(mk(MEM_READ_WORD,  32'h010, 32'h0, 1'b1, 32'h77223344, 1'b0, 1, 1, 4'h0, 4'h0));
      // Misaligned traffic: split in one build, faulted in the other
      vecs.push_back(mk(MEM_STORE_HALF, 32'h001, 32'h00001234, 1'b0, 32'h0, !MIS, 1, MIS ? 1 : 0,
                        MIS ? 4'h6 : 4'h0, 4'h0));
      vecs.push_back(mk(MEM_READ_WORD,  32'h000, 32'h0, 1'b1, MIS ? 32'hAA123400 : 32'hAA000000,
                        1'b0, 1, 1, 4'h0, 4'h0));
      vecs.push_back(mk(MEM_READ_WORD,  32'h003, 32'h0, 1'b1, MIS ? 32'hCCBBDDAA : 32'h0,
                        !MIS, MIS ? 2 : 1, MIS ? 2 : 0, 4'h0, 4'h0));
      vecs.push_back(mk(MEM_READ_HALF,  32'h003, 32'h0, 1'b1, MIS ? 32'h0000DDAA : 32'h0,
                        !MIS, MIS ? 2 : 1, MIS ? 2 : 0, 4'h0, 4'h0));
      vecs.push_back(mk(MEM_READ_HALF,  32'h001, 32'h0, 1'b1, MIS ? 32'h00001234 : 32'h0,
                        !MIS, 1, MIS ? 1 : 0, 4'h0, 4'h0));
      vecs.push_back(mk(MEM_READ_BYTE,  32'h003, 32'h0, 1'b1, 32'h000000AA, 1'b0, 1, 1, 4'h0, 4'h0));
      vecs.push_back(mk(MEM_STORE_WORD, 32'hFFE, 32'hA1B2C3D4, 1'b0, 32'h0, !MIS, MIS ? 2 : 1,
                        MIS ? 2 : 0, MIS ? 4'hC : 4'h0, MIS ? 4'h3 : 4'h0));
      vecs.push_back(mk(MEM_READ_WORD,  32'hFFE, 32'h0, 1'b1, MIS ? 32'hA1B2C3D4 : 32'h0,
                        !MIS, MIS ? 2 : 1, MIS ? 2 : 0, 4'h0, 4'h0));

      // Reset with a request pending: everything must stay quiet
      rst = 1'b0; mem_ctrl = MEM_READ_WORD; mem_addr = 32'h010; mem_din = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'h0, mem_ready}, 32'h0);
      chk("rst_fault", {31'h0, mem_fault}, 32'h0);
      chk("rst_dout", mem_dout, 32'h0);
      chk("rst_en", {31'h0, ram_en}, 32'h0);
      chk("rst_we", {28'h0, ram_we}, 32'h0);
      rst = 1'b1; mem_ctrl = MEM_NONE;
      @(negedge clk);
      chk("idle_en", {31'h0, ram_en}, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         run_req(v.ctrl, v.addr, v.din, r_dout, r_fault, r_lat, r_ens, r_we0, r_we1, r_idle);
         chk($sformatf("v%0d_lat", i), r_lat, v.lat);
         chk($sformatf("v%0d_ens", i), r_ens, v.ens);
         chk($sformatf("v%0d_we0", i), {28'h0, r_we0}, {28'h0, v.we0});
         chk($sformatf("v%0d_we1", i), {28'h0, r_we1}, {28'h0, v.we1});
         chk($sformatf("v%0d_fault", i), {31'h0, r_fault}, {31'h0, v.fault});
         chk($sformatf("v%0d_idle_dout", i), {31'h0, r_idle}, 32'h1);
         if (v.chk_dout) chk($sformatf("v%0d_dout", i), r_dout, v.dout);
      end

      // Memory image after half, wrap-around and faulted stores
      chk("ram_040", ram[10'h040], 32'hBEEF0000);
      chk("ram_3ff", ram[10'h3FF], MIS ? 32'hC3D47788 : 32'h55667788);
      chk("ram_000", ram[10'h000], MIS ? 32'hAA12A1B2 : 32'hAA000000);

      // Reset while a misaligned request is in flight (SECOND or RESP)
      @(negedge clk);
      mem_ctrl = MEM_READ_WORD; mem_addr = 32'h003;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_ready", {31'h0, mem_ready}, 32'h0);
      chk("mid_rst_fault", {31'h0, mem_fault}, 32'h0);
      chk("mid_rst_dout", mem_dout, 32'h0);
      chk("mid_rst_en", {31'h0, ram_en}, 32'h0);
      chk("mid_rst_we", {28'h0, ram_we}, 32'h0);
      @(negedge clk);
      chk("post_rst_en", {31'h0, ram_en}, 32'h0);
      chk("post_rst_ready", {31'h0, mem_ready}, 32'h0);
      rst = 1'b1; mem_ctrl = MEM_NONE;
      run_req(MEM_READ_BYTE, 32'h010, 32'h0, r_dout, r_fault, r_lat, r_ens, r_we0, r_we1, r_idle);
      chk("after_rst_lat", r_lat, 1);
      chk("after_rst_dout", r_dout, 32'h00000044);
      chk("after_rst_fault", {31'h0, r_fault}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_adapter.md
MEM_ADAPTER -- requirements
Module: mem_adapter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the byte-address width of the attached RAM (4 KiB).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port mem_ctrl, input, mem_ctrl_t: core request (NONE, READ_BYTE/HALF/WORD, STORE_BYTE/HALF/WORD).
REQ-005 SHALL have port mem_addr, input, 32 bits: core byte address.
REQ-006 SHALL have port mem_din, input, 32 bits: core store data, right-aligned.
REQ-007 SHALL have port mem_dout, output, 32 bits: load data, right-aligned and zero-extended.
REQ-008 SHALL have port mem_ready, output, 1 bit: one-cycle pulse completing the request.
REQ-009 SHALL have port mem_fault, output, 1 bit: misaligned-access fault, qualified by mem_ready.
REQ-010 SHALL have port ram_addr, output, ADDR_W-2 bits: RAM word address.
REQ-011 SHALL have port ram_en, output, 1 bit: RAM access enable.
REQ-012 SHALL have port ram_we, output, 4 bits: per-byte write enables, bit i = byte lane i.
REQ-013 SHALL have port ram_wdata, output, 32 bits: lane-positioned write data.
REQ-014 SHALL have port ram_rdata, input, 32 bits: RAM read data, valid one cycle after ram_en.

Function
REQ-015 SHALL be little-endian; byte at address A is in lane A[1:0] of word A[ADDR_W-1:2].
REQ-016 SHALL require the core to hold mem_ctrl/mem_addr/mem_din stable until mem_ready.
REQ-017 SHALL implement states IDLE, SECOND, RESP.
REQ-018 IDLE with NONE: ram_en=0, ram_we=0, stay IDLE.
REQ-019 IDLE with an aligned or single-word request: issue first RAM access this cycle; go to RESP.
REQ-020 IDLE with a request spanning two words: issue the lower word; go to SECOND.
REQ-021 SECOND: capture lower-word read bytes; issue the upper word (word+1); go to RESP.
REQ-022 RESP: mem_ready=1, mem_dout valid, ram_en=0, ram_we=0; go to IDLE unconditionally.
REQ-023 Latency SHALL be 1 cycle (aligned) or 2 cycles (split) from request to mem_ready; throughput is at most one request per 2 cycles.
REQ-024 Address bits above ADDR_W SHALL be ignored; word+1 of the last word SHALL wrap to word 0.
REQ-025 Store byte enables SHALL cover exactly the addressed bytes; other lanes are untouched.
REQ-026 mem_dout SHALL be 0 whenever mem_ready=0.

Reset
REQ-027 While rst=0: state IDLE, mem_ready=0, mem_fault=0, mem_dout=0, ram_en=0, ram_we=0, regardless of mem_ctrl.
REQ-028 Reset in SECOND or RESP SHALL abandon the request; partial split stores are not rolled back.

Configuration
REQ-029 Macro MEM_ADAPTER_MISALIGN_EN defined: split accesses per REQ-020/021; mem_fault tied 0.
REQ-030 Macro undefined: a misaligned half (A[0]=1) or word (A[1:0]!=0) SHALL go IDLE->RESP with no RAM access, mem_fault=1, mem_dout=0; no SECOND state logic.

Structure
REQ-031 The state enum and the lane-mask constants SHALL be in the shared types package beside mem_ctrl_t.
REQ-032 The combinational sub-module mem_lane_align SHALL generate byte enables, write-data rotation and read-data extraction.

Verification
REQ-033 READ_WORD at 0x010, RAM word 0x11223344 -> ram_en one cycle, mem_ready next cycle, mem_dout=0x11223344, fault=0.
REQ-034 STORE_HALF 0xBEEF at 0x102 -> ram_we=4'b1100, ram_wdata[31:16]=0xBEEF; then READ_BYTE 0x103 -> mem_dout=0x000000BE.
REQ-035 MISALIGN_EN: READ_WORD at 0x003 with words 0x00=0xAA000000 and 0x04=0x00CCBBDD -> two RAM cycles, mem_dout=0xCCBBDDAA.
REQ-036 MISALIGN_EN: STORE_WORD 0xA1B2C3D4 at 0xFFE (ADDR_W=12) -> word 0x3FF we=4'b1100, then word 0x000 we=4'b0011; readback equals 0xA1B2C3D4.
REQ-037 Undefined macro: STORE_HALF at 0x001 -> no ram_we, mem_ready with mem_fault=1, memory unchanged.
REQ-038 rst=0 asserted in SECOND -> next cycle IDLE, all outputs 0; a new READ_BYTE then completes normally.
